// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU widths, the write-back entry type and a one-hot
//               address decoder used by the register-file write-back logic.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Decode a register address into a one-hot register mask.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry synchronous FIFO of write-back entries. Head is
//               valid whenever o_empty is low. Push while full and pop while
//               empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam logic [1:0] c_DEPTH = 2'd2;

  wb_entry_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic       w_push_ok;
  logic       w_pop_ok;

  assign w_push_ok = i_push & (r_count != c_DEPTH);
  assign w_pop_ok  = i_pop  & (r_count != 2'd0);

  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage: entries are only read once written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Register-file write-back arbiter. Merges single-cycle ALU
//               results with buffered load results onto the one register-file
//               write port, bounds load starvation with a saturating age
//               counter, and tracks outstanding writes for hazard queries.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // ALU result channel
  input  logic              i_alu_vld,
  input  logic [ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_rdy,
  // Load result channel
  input  logic              i_mem_vld,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_mem_rdy,
  // Destination reservation from issue
  input  logic              i_issue_vld,
  input  logic [ADDR_W-1:0] i_issue_addr,
  // Hazard queries
  input  logic [ADDR_W-1:0] i_q0_addr,
  input  logic [ADDR_W-1:0] i_q1_addr,
  output logic              o_q0_busy,
  output logic              o_q1_busy,
  // Register-file write port
  output logic              o_we,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic [DATA_W-1:0] o_dst
);

  localparam logic [1:0]          c_AGE_MAX = 2'd3;
  localparam logic [NUM_REGS-1:0] c_R0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  // Registered state
  logic [1:0]          r_age;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_we;
  logic [ADDR_W-1:0]   r_dst_addr;
  logic [DATA_W-1:0]   r_dst;

  // FIFO interface
  wb_entry_t           w_push_entry;
  wb_entry_t           w_fifo_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;

  // Arbitration
  logic                w_age_sat;
  logic                w_alu_acc;
  logic                w_gnt;
  wb_entry_t           w_gnt_entry;

  // Scoreboard update masks
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  assign w_push_entry = '{addr: i_mem_addr, data: i_mem_data};

  wb_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // A load head that has waited the maximum age blocks the ALU for one cycle.
  assign w_age_sat = (r_age == c_AGE_MAX);
  assign o_alu_rdy = ~rst & ~(w_age_sat & ~w_fifo_empty);
  assign o_mem_rdy = ~rst & ~w_fifo_full;

  assign w_alu_acc = i_alu_vld & o_alu_rdy;
  assign w_push    = i_mem_vld & o_mem_rdy;
  // The FIFO head takes the port whenever the ALU does not.
  assign w_pop     = ~rst & ~w_alu_acc & ~w_fifo_empty;
  assign w_gnt     = w_alu_acc | w_pop;

  // Select the entry that owns the write port this cycle.
  always_comb begin
    w_gnt_entry = w_fifo_head;
    if (w_alu_acc) begin
      w_gnt_entry = '{addr: i_alu_addr, data: i_alu_data};
    end
  end

  // Age of the FIFO head: counts cycles it is present but passed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= 2'd0;
    end else if (w_fifo_empty || w_pop) begin
      r_age <= 2'd0;
    end else if (!w_age_sat) begin
      r_age <= r_age + 2'd1;
    end
  end

  // Write-port register; R0 grants complete but never assert the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_dst_addr <= '0;
      r_dst      <= '0;
    end else begin
      r_we <= w_gnt & (w_gnt_entry.addr != '0);
      if (w_gnt) begin
        r_dst_addr <= w_gnt_entry.addr;
        r_dst      <= w_gnt_entry.data;
      end
    end
  end

  assign o_we       = r_we;
  assign o_dst_addr = r_dst_addr;
  assign o_dst      = r_dst;

  assign w_clr_vec = r_we ? addr_onehot(r_dst_addr) : '0;
  assign w_set_vec = (i_issue_vld && (i_issue_addr != '0)) ? addr_onehot(i_issue_addr) : '0;

  // Scoreboard: a new reservation overrides a retiring write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_vec) | w_set_vec) & c_R0_MASK;
    end
  end

  // A register being written this cycle reads through the rf bypass, so it is free.
  assign o_q0_busy = r_busy[i_q0_addr] & ~(r_we & (r_dst_addr == i_q0_addr));
  assign o_q1_busy = r_busy[i_q1_addr] & ~(r_we & (r_dst_addr == i_q1_addr));

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back side of the CPU register file: collects results from the single-cycle ALU and the multi-cycle memory/load unit and drives the register file's single write port (`we`, `dst_addr`, `dst`), one write per cycle. It also keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards. The scoreboard accounts for the register file's same-cycle write-to-read bypass. It sits between the execute/memory stages and `rf`.

## Interface
- `DATA_W`, 16, result/data width
- `ADDR_W`, 4, register address width (16 registers; R0 hardwired zero)
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `alu_vld`  in  1  ALU result valid
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_rdy`  out  1  ALU result accepted when `alu_vld & alu_rdy`
- `mem_vld`  in  1  load result valid
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load result
- `mem_rdy`  out  1  load result accepted when `mem_vld & mem_rdy`
- `issue_vld`  in  1  issue stage reserves a destination this cycle
- `issue_addr`  in  ADDR_W  reserved destination
- `q0_addr`, `q1_addr`  in  ADDR_W  hazard query addresses (source operands)
- `q0_busy`, `q1_busy`  out  1  combinational: the queried register has an outstanding write
- `we`  out  1  register file write enable (registered)
- `dst_addr`  out  ADDR_W  register file write address (registered)
- `dst`  out  DATA_W  register file write data (registered)

## Operation
- Load results always enter a 2-entry FIFO on `mem_vld & mem_rdy`.
- `mem_rdy = ~full & ~rst`. There is no pass-through when the FIFO is full.
- Arbitration each cycle, in this order:
  - If `alu_rdy & alu_vld`, the ALU wins.
  - Else, if the FIFO is non-empty, the FIFO head pops.
  - Else, no write.
- Anti-starvation uses `age`, a 2-bit saturating counter:
  - Increments each cycle the FIFO head is present and not granted.
  - Clears on pop, and clears whenever the FIFO is empty.
  - `alu_rdy = ~rst & ~(age == 3 & ~empty)`.
  - While `alu_rdy` is low, the FIFO head is granted unconditionally.
- Granted entries are registered onto `we`/`dst_addr`/`dst` the next cycle.
- Entries with address 0 are handshaken and granted, but drive `we = 0` and do not touch the scoreboard.
- Scoreboard is a 16-bit `busy` vector:
  - Set at the edge where `issue_vld & issue_addr != 0`.
  - Cleared at the edge ending a cycle with `we` high for that address.
  - Set and clear on the same address in the same cycle: set wins.
  - `busy[0]` is always 0.
- Query logic: `qN_busy = busy[qN_addr] & ~(we & dst_addr == qN_addr)`. A register being written this cycle is reported free because `rf` bypasses `dst` to its read ports.
- A write to a register with no reservation is legal. It is written, and the scoreboard is unchanged.

## Timing
- Reset values:
  - `we = 0`, `dst_addr = 0`, `dst = 0`.
  - `busy = 0`, FIFO empty, `age = 0`.
  - `alu_rdy = 0`, `mem_rdy = 0` while `rst` is high.
- Reset mid-operation discards FIFO contents and all reservations at that edge.
- ALU latency: accepted at edge N, `we` high throughout cycle N+1. `rf` writes during that cycle.
- Load latency: pushed at edge N, head visible in cycle N+1. Earliest grant is cycle N+1, so `we` is high in cycle N+2.
- `we` is high for exactly one cycle per non-R0 grant. Back-to-back grants give back-to-back `we`.
- FIFO is full after 2 un-popped pushes, and `mem_rdy` drops the following cycle. A pop and a push in the same cycle keep the occupancy unchanged.
- Worst-case wait for a load head is 3 cycles of ALU traffic, then a forced grant on the 4th cycle.

## Structure
- Shared `cpu_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS = 16`.
  - `wb_entry_t` struct: `addr`, `data`.
- Sub-module `wb_fifo2`: 2-entry synchronous FIFO of `wb_entry_t` with push/pop, full/empty and a head output.
- Arbiter, age counter, output register and scoreboard live in the top module.

## Test plan
- Reset release with all inputs idle:
  - `we = 0`, `dst_addr = 0`, `dst = 0`, both `busy` outputs 0.
  - `alu_rdy = mem_rdy = 1` one cycle after `rst` falls.
- Reserve R5 via issue, then ALU writes `0x1234` to R5:
  - `q0_busy(5)` is 1 until the write cycle.
  - `q0_busy(5)` is 0 in the cycle where `we = 1`, `dst_addr = 5`, `dst = 0x1234`.
  - `q0_busy(5)` stays 0 afterwards.
- ALU valid every cycle while a load to R3 (`0xBEEF`) is pushed:
  - `alu_rdy` drops once after the load head waits 3 cycles.
  - R3/`0xBEEF` is written in the next cycle.
  - ALU writes then resume.
- Three loads with no pops possible, because ALU traffic is continuous:
  - `mem_rdy` goes low after the 2nd push.
  - The 3rd load is held until a pop.
  - Write order: R1, R2, R3.
- ALU writes `0xFFFF` to R0 after `issue_addr = 0`:
  - Handshake completes and `we` stays 0.
  - `busy` stays all-zero.
- Assert `rst` with 2 FIFO entries pending and R7 reserved:
  - Next cycle: FIFO empty, `busy[7] = 0`, `we = 0`.
  - No stale write appears after `rst` falls.
